// File: rtl/mips_div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI.
// One quotient bit per cycle over magnitudes; signs are restored in a single fixup cycle.
module mips_div_unit #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]  rem_q, quo_q, dvsMag_q, rawDividend_q;
  logic              quoNeg_q, remNeg_q, divZero_q;
  logic [ITER_W-1:0] cnt_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              dbz_q;

  logic              dividendNeg, divisorNeg;
  logic [WIDTH-1:0]  dividendMag, divisorMag;
  logic [WIDTH:0]    shifted;
  logic              fits;
  logic [WIDTH-1:0]  trialDiff, remStep, quoStep;
  logic [WIDTH-1:0]  quoFix, remFix, finalHi, finalLo;
  logic              lastIter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (flush_i)       state_d = S_IDLE;
        else if (lastIter) state_d = S_FIX;
      end
      S_FIX:  state_d = flush_i ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_RUN) || (state_q == S_FIX);
    done_o = (state_q == S_DONE);
  end

  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

  // A set top bit in the shifted remainder means it already exceeds any 32-bit divisor,
  // so the low WIDTH bits of the difference are exact whenever the trial succeeds.
  always_comb begin
    dividendNeg = is_signed_i & dividend_i[WIDTH-1];
    divisorNeg  = is_signed_i & divisor_i[WIDTH-1];
    dividendMag = dividendNeg ? -dividend_i : dividend_i;
    divisorMag  = divisorNeg  ? -divisor_i  : divisor_i;

    shifted   = {rem_q, quo_q[WIDTH-1]};
    fits      = shifted >= {1'b0, dvsMag_q};
    trialDiff = shifted[WIDTH-1:0] - dvsMag_q;
    remStep   = fits ? trialDiff : shifted[WIDTH-1:0];
    quoStep   = {quo_q[WIDTH-2:0], fits};
    lastIter  = (cnt_q == ITER_W'(WIDTH - 1));

    quoFix  = quoNeg_q ? -quo_q : quo_q;
    remFix  = remNeg_q ? -rem_q : rem_q;
    finalLo = divZero_q ? '1 : quoFix;
    finalHi = divZero_q ? rawDividend_q : remFix;
  end

  // The fixup edge writes HI/LO directly so results are visible in the same cycle as done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q         <= '0;
      quo_q         <= '0;
      dvsMag_q      <= '0;
      rawDividend_q <= '0;
      quoNeg_q      <= 1'b0;
      remNeg_q      <= 1'b0;
      divZero_q     <= 1'b0;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      dbz_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_q         <= '0;
            quo_q         <= dividendMag;
            dvsMag_q      <= divisorMag;
            rawDividend_q <= dividend_i;
            quoNeg_q      <= dividendNeg ^ divisorNeg;
            remNeg_q      <= dividendNeg;
            divZero_q     <= (divisor_i == '0);
            cnt_q         <= '0;
          end
        end
        S_RUN: begin
          if (!flush_i) begin
            rem_q <= remStep;
            quo_q <= quoStep;
            cnt_q <= cnt_q + ITER_W'(1);
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            hi_q  <= finalHi;
            lo_q  <= finalLo;
            dbz_q <= divZero_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Directed self-checking bench for mips_div_unit; each task covers one scenario
// with hand-computed quotient/remainder and the fixed 34-cycle done latency.
module tb_mips_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        isSigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  mips_div_unit #(.WIDTH(32), .ITER_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .is_signed_i  (isSigned),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .flush_i      (flush),
    .busy_o       (busy),
    .done_o       (done),
    .div_by_zero_o(divByZero),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a one-cycle start; returns at the negedge of cycle 1 (first cycle after E0).
  task automatic startOp(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    isSigned = sgn;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitDone(output int doneCycle, output int busyCycles);
    doneCycle  = -1;
    busyCycles = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busyCycles++;
      if (done) begin
        doneCycle = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, divByZero} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy/done/dbz=%b required 000", {busy, done, divByZero});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_hilo: got hi=%h lo=%h required 0/0", hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_divu_basic;
    int dc, bc;
    startOp(32'd100, 32'd7, 1'b0);
    waitDone(dc, bc);
    checks++;
    if (dc !== 34) begin
      errors++;
      $display("[TB] FAIL divu_latency: got %0d required 34", dc);
    end
    checks++;
    if (bc !== 33) begin
      errors++;
      $display("[TB] FAIL divu_busy_cycles: got %0d required 33", bc);
    end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || divByZero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL divu_100_7: got lo=%0d hi=%0d dbz=%b required 14/2/0", lo, hi, divByZero);
    end
  endtask

  task automatic test_div_signed;
    int dc, bc;
    startOp(32'hFFFF_FFF9, 32'd2, 1'b1);
    waitDone(dc, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL div_neg7_2: got lo=%h hi=%h required fffffffd/ffffffff", lo, hi);
    end
    startOp(32'd7, 32'hFFFF_FFFE, 1'b1);
    waitDone(dc, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      errors++;
      $display("[TB] FAIL div_7_neg2: got lo=%h hi=%h required fffffffd/00000001", lo, hi);
    end
  endtask

  task automatic test_div_zero;
    int dc, bc;
    startOp(32'h1234_5678, 32'd0, 1'b0);
    waitDone(dc, bc);
    checks++;
    if (dc !== 34) begin
      errors++;
      $display("[TB] FAIL dbz_latency: got %0d required 34", dc);
    end
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678 || divByZero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_result: got lo=%h hi=%h dbz=%b required ffffffff/12345678/1", lo, hi, divByZero);
    end
    // Signed negative dividend: hi must be the raw input, not a magnitude.
    startOp(32'hFFFF_FFF9, 32'd0, 1'b1);
    waitDone(dc, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9 || divByZero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_signed: got lo=%h hi=%h dbz=%b required ffffffff/fffffff9/1", lo, hi, divByZero);
    end
    startOp(32'd100, 32'd7, 1'b0);
    waitDone(dc, bc);
    checks++;
    if (divByZero !== 1'b0 || lo !== 32'd14) begin
      errors++;
      $display("[TB] FAIL dbz_clear: got dbz=%b lo=%0d required 0/14", divByZero, lo);
    end
  endtask

  task automatic test_overflow;
    int dc, bc;
    startOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone(dc, bc);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      errors++;
      $display("[TB] FAIL div_overflow: got lo=%h hi=%h required 80000000/00000000", lo, hi);
    end
    startOp(32'hFFFF_FFFF, 32'd1, 1'b0);
    waitDone(dc, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h0) begin
      errors++;
      $display("[TB] FAIL divu_max_1: got lo=%h hi=%h required ffffffff/00000000", lo, hi);
    end
  endtask

  task automatic test_contention;
    int dc;
    int doneSeen;
    startOp(32'd100, 32'd7, 1'b0);
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      if (c == 10) begin
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (dc !== 34 || lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("[TB] FAIL start_while_busy: got cycle=%0d lo=%0d hi=%0d required 34/14/2", dc, lo, hi);
    end
    startOp(32'd50, 32'd5, 1'b0);
    for (int c = 1; c < 20; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_busy_drop: got busy=%b required 0", busy);
    end
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("[TB] FAIL flush_no_done: got %0d done pulses required 0", doneSeen);
    end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("[TB] FAIL flush_hold_hilo: got lo=%0d hi=%0d required 14/2", lo, hi);
    end
  endtask

  task automatic test_back_to_back;
    int dc, bc;
    startOp(32'd9, 32'd2, 1'b0);
    waitDone(dc, bc);
    // start raised during the done cycle lands while still in DONE and must be dropped
    dividend = 32'd8;
    divisor  = 32'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_on_done: got busy=%b done=%b required 0/0", busy, done);
    end
    checks++;
    if (lo !== 32'd4 || hi !== 32'd1) begin
      errors++;
      $display("[TB] FAIL divu_9_2: got lo=%0d hi=%0d required 4/1", lo, hi);
    end
  endtask

  task automatic test_async_reset;
    int dc, bc;
    startOp(32'd100, 32'd7, 1'b0);
    for (int c = 1; c < 15; c++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, divByZero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h required all 0",
               busy, done, divByZero, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    startOp(32'd9, 32'd3, 1'b0);
    waitDone(dc, bc);
    checks++;
    if (dc !== 34 || lo !== 32'd3 || hi !== 32'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_9_3: got cycle=%0d lo=%0d hi=%0d required 34/3/0", dc, lo, hi);
    end
  endtask

  initial begin
    start    = 1'b0;
    isSigned = 1'b0;
    dividend = '0;
    divisor  = '0;
    flush    = 1'b0;
    rst_n    = 1'b1;
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_contention();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
